// File: rtl/prio_queue_pkg.sv
// Shared types, default widths and helpers for the sorted priority queue.
// An entry is {prio, id}; a larger prio is more urgent.
package prio_queue_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int PRIO_W_DEF  = 2;
  localparam int ID_W_DEF    = 2;
  localparam int ENTRY_W_DEF = PRIO_W_DEF + ID_W_DEF;

  typedef struct packed {
    logic [PRIO_W_DEF-1:0] prio;
    logic [ID_W_DEF-1:0]   id;
  } entry_t;

  // Per-slot action for one clock edge
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_UP,
    OP_DOWN,
    OP_LOAD,
    OP_CLEAR
  } slot_op_e;

  // Priority field of an entry of any width up to 32 bits; the caller truncates.
  function automatic logic [31:0] prio_of(input logic [31:0] data, input int unsigned id_w);
    return data >> id_w;
  endfunction

endpackage

// File: rtl/prio_queue_sorted_if.sv
// Enqueue/dequeue handshake and status bundle for prio_queue_sorted.
// Handshake: a transfer fires on a rising edge when valid && ready; valid never waits on ready.
interface prio_queue_sorted_if
  import prio_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PRIO_W = PRIO_W_DEF,
  parameter int ID_W   = ID_W_DEF
) ();

  localparam int W  = PRIO_W + ID_W;
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [W-1:0]  enq_data;
  logic          deq_valid;
  logic          deq_ready;
  logic [W-1:0]  deq_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  // Queue side
  modport slave (
    input  flush, enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count, full, empty
  );

  // Producer/consumer side
  modport master (
    output flush, enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count, full, empty
  );

endinterface

// File: rtl/prio_queue_slot.sv
// One storage slot of the sorted queue: picks hold, shift-up, shift-down,
// load-new or clear from the insert position and the fire controls.
module prio_queue_slot
  import prio_queue_pkg::*;
#(
  parameter int IDX = 0,
  parameter int W   = ENTRY_W_DEF,
  parameter int KW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          enq_fire_i,
  input  logic          deq_fire_i,
  input  logic [KW-1:0] ins_pos_i,
  input  logic [W-1:0]  new_data_i,
  input  logic [W-1:0]  up_data_i,
  input  logic          up_valid_i,
  input  logic [W-1:0]  dn_data_i,
  input  logic          dn_valid_i,
  output logic [W-1:0]  data_o,
  output logic          valid_o
);

  localparam logic [KW-1:0] IDX_K = KW'(IDX);

  slot_op_e     op;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // With both fires, ins_pos_i is already the position in the post-dequeue order
  always_comb begin
    op = OP_HOLD;
    if (flush_i) begin
      op = OP_CLEAR;
    end else if (enq_fire_i && deq_fire_i) begin
      if (IDX_K < ins_pos_i)       op = OP_DOWN;
      else if (IDX_K == ins_pos_i) op = OP_LOAD;
    end else if (enq_fire_i) begin
      if (IDX_K == ins_pos_i)      op = OP_LOAD;
      else if (IDX_K > ins_pos_i)  op = OP_UP;
    end else if (deq_fire_i) begin
      op = OP_DOWN;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (op)
      OP_CLEAR: begin data_d = '0;         valid_d = 1'b0;       end
      OP_UP:    begin data_d = up_data_i;  valid_d = up_valid_i; end
      OP_DOWN:  begin data_d = dn_data_i;  valid_d = dn_valid_i; end
      OP_LOAD:  begin data_d = new_data_i; valid_d = 1'b1;       end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/prio_queue_sorted.sv
// Sorted-register priority queue: head is always the most urgent, oldest entry,
// so dequeue is a plain shift and needs no search.
module prio_queue_sorted
  import prio_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PRIO_W = PRIO_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input logic               clk,
  input logic               rst,
  prio_queue_sorted_if.slave q_if
);

  localparam int W  = PRIO_W + ID_W;
  localparam int KW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]      data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  goes_before;
  logic [PRIO_W-1:0] new_prio;
  logic [KW-1:0]     k;
  logic [KW-1:0]     ins_pos;
  logic [CW-1:0]     count_q, count_d;
  logic              full, empty;
  logic              enq_fire, deq_fire;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign enq_fire = q_if.enq_valid && !full;
  assign deq_fire = q_if.deq_ready && !empty;
  assign new_prio = PRIO_W'(prio_of(32'(q_if.enq_data), ID_W));

  // Strictly-greater keeps equal priorities in arrival order
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign goes_before[i] = !valid_q[i] || (new_prio > data_q[i][W-1 -: PRIO_W]);
  end

  always_comb begin
    k = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (goes_before[i]) k = KW'(i);
    end
  end

  // Head leaves in the same edge: shift the insert point down by one
  assign ins_pos = (deq_fire && (k != '0)) ? k - KW'(1) : k;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [W-1:0] up_data, dn_data;
    logic         up_valid, dn_valid;

    if (i == 0) begin : g_first
      assign up_data  = '0;
      assign up_valid = 1'b0;
    end else begin : g_up
      assign up_data  = data_q[i-1];
      assign up_valid = valid_q[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign dn_data  = '0;
      assign dn_valid = 1'b0;
    end else begin : g_dn
      assign dn_data  = data_q[i+1];
      assign dn_valid = valid_q[i+1];
    end

    prio_queue_slot #(
      .IDX (i),
      .W   (W),
      .KW  (KW)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (q_if.flush),
      .enq_fire_i (enq_fire),
      .deq_fire_i (deq_fire),
      .ins_pos_i  (ins_pos),
      .new_data_i (q_if.enq_data),
      .up_data_i  (up_data),
      .up_valid_i (up_valid),
      .dn_data_i  (dn_data),
      .dn_valid_i (dn_valid),
      .data_o     (data_q[i]),
      .valid_o    (valid_q[i])
    );
  end

  always_comb begin
    count_d = count_q;
    if (q_if.flush) begin
      count_d = '0;
    end else if (enq_fire && !deq_fire) begin
      count_d = count_q + CW'(1);
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign q_if.count     = count_q;
  assign q_if.full      = full;
  assign q_if.empty     = empty;
  assign q_if.enq_ready = !full;
  assign q_if.deq_valid = !empty;
  assign q_if.deq_data  = data_q[0];

endmodule

// File: tb/tb_prio_queue_sorted.sv
// Directed bench for prio_queue_sorted with DEPTH=4, PRIO_W=2, ID_W=2.
module tb_prio_queue_sorted;

  localparam int DEPTH  = 4;
  localparam int PRIO_W = 2;
  localparam int ID_W   = 2;
  localparam int W      = PRIO_W + ID_W;
  localparam int CW     = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;

  always #5 clk = ~clk;

  prio_queue_sorted_if #(.DEPTH(DEPTH), .PRIO_W(PRIO_W), .ID_W(ID_W)) q_if ();

  prio_queue_sorted #(.DEPTH(DEPTH), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (q_if)
  );

  // ---------------- driver tasks ----------------
  task automatic enq(input logic [W-1:0] d);
    @(negedge clk);
    q_if.enq_valid = 1'b1;
    q_if.enq_data  = d;
    @(posedge clk); #1;
    q_if.enq_valid = 1'b0;
    q_if.enq_data  = '0;
  endtask

  task automatic idle_inputs();
    q_if.flush     = 1'b0;
    q_if.enq_valid = 1'b0;
    q_if.enq_data  = '0;
    q_if.deq_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (q_if.count !== '0 || q_if.empty !== 1'b1 || q_if.full !== 1'b0 ||
        q_if.enq_ready !== 1'b1 || q_if.deq_valid !== 1'b0 || q_if.deq_data !== '0) begin
      errors++;
      $display("FAIL reset got count=%0d empty=%b full=%b enq_rdy=%b deq_v=%b data=%h exp 0 1 0 1 0 0",
               q_if.count, q_if.empty, q_if.full, q_if.enq_ready, q_if.deq_valid, q_if.deq_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ordering();
    enq(4'h1); enq(4'hE); enq(4'h6); enq(4'hD);
    checks++;
    if (q_if.full !== 1'b1 || q_if.count !== CW'(4)) begin
      errors++;
      $display("FAIL order_full got full=%b count=%0d exp 1 4", q_if.full, q_if.count);
    end
    exp_q = '{4'hE, 4'hD, 4'h6, 4'h1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      q_if.deq_ready = 1'b1;
      exp = exp_q.pop_front();
      checks++;
      if (q_if.deq_valid !== 1'b1 || q_if.deq_data !== exp) begin
        errors++;
        $display("FAIL order_deq[%0d] got v=%b %h exp 1 %h", i, q_if.deq_valid, q_if.deq_data, exp);
      end
      @(posedge clk); #1;
    end
    q_if.deq_ready = 1'b0;
    checks++;
    if (q_if.empty !== 1'b1 || q_if.deq_data !== '0) begin
      errors++;
      $display("FAIL order_empty got empty=%b data=%h exp 1 0", q_if.empty, q_if.deq_data);
    end
  endtask

  task automatic test_stability();
    enq(4'h9); enq(4'hB); enq(4'h8);
    exp_q = '{4'h9, 4'hB, 4'h8};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      q_if.deq_ready = 1'b1;
      exp = exp_q.pop_front();
      checks++;
      if (q_if.deq_data !== exp) begin
        errors++;
        $display("FAIL stable_deq[%0d] got %h exp %h", i, q_if.deq_data, exp);
      end
      @(posedge clk); #1;
    end
    q_if.deq_ready = 1'b0;
  endtask

  task automatic test_full();
    enq(4'h4); enq(4'h8); enq(4'hC); enq(4'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      q_if.enq_valid = 1'b1;
      q_if.enq_data  = 4'hF;
      checks++;
      if (q_if.enq_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_ready[%0d] got %b exp 0", i, q_if.enq_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (q_if.count !== CW'(4)) begin
        errors++;
        $display("FAIL full_count[%0d] got %0d exp 4", i, q_if.count);
      end
    end
    // Full with a dequeue in the same cycle: still no enqueue accepted
    @(negedge clk);
    q_if.deq_ready = 1'b1;
    checks++;
    if (q_if.enq_ready !== 1'b0 || q_if.deq_data !== 4'hC) begin
      errors++;
      $display("FAIL full_deq got rdy=%b data=%h exp 0 c", q_if.enq_ready, q_if.deq_data);
    end
    @(posedge clk); #1;
    q_if.enq_valid = 1'b0;
    q_if.enq_data  = '0;
    checks++;
    if (q_if.count !== CW'(3)) begin
      errors++;
      $display("FAIL full_deq_count got %0d exp 3", q_if.count);
    end
    exp_q = '{4'h8, 4'h4, 4'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (q_if.deq_valid !== 1'b1 || q_if.deq_data !== exp) begin
        errors++;
        $display("FAIL full_drain[%0d] got v=%b %h exp 1 %h", i, q_if.deq_valid, q_if.deq_data, exp);
      end
      @(posedge clk); #1;
    end
    q_if.deq_ready = 1'b0;
    checks++;
    if (q_if.empty !== 1'b1) begin
      errors++;
      $display("FAIL full_end_empty got %b exp 1", q_if.empty);
    end
  endtask

  task automatic test_simultaneous();
    enq(4'h8); enq(4'h4);
    @(negedge clk);
    q_if.enq_valid = 1'b1;
    q_if.enq_data  = 4'hC;
    q_if.deq_ready = 1'b1;
    checks++;
    if (q_if.deq_data !== 4'h8) begin
      errors++;
      $display("FAIL simul_head got %h exp 8", q_if.deq_data);
    end
    @(posedge clk); #1;
    q_if.enq_valid = 1'b0;
    q_if.enq_data  = '0;
    checks++;
    if (q_if.deq_data !== 4'hC || q_if.count !== CW'(2)) begin
      errors++;
      $display("FAIL simul_after got %h count=%0d exp c 2", q_if.deq_data, q_if.count);
    end
    @(posedge clk); #1;
    q_if.deq_ready = 1'b0;
    checks++;
    if (q_if.deq_data !== 4'h4 || q_if.count !== CW'(1)) begin
      errors++;
      $display("FAIL simul_tail got %h count=%0d exp 4 1", q_if.deq_data, q_if.count);
    end
    @(negedge clk);
    q_if.deq_ready = 1'b1;
    @(posedge clk); #1;
    q_if.deq_ready = 1'b0;
  endtask

  task automatic test_empty();
    q_if.deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q_if.count !== '0 || q_if.deq_data !== '0 || q_if.deq_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_deq[%0d] got count=%0d data=%h v=%b exp 0 0 0",
                 i, q_if.count, q_if.deq_data, q_if.deq_valid);
      end
    end
    @(negedge clk);
    q_if.enq_valid = 1'b1;
    q_if.enq_data  = 4'h9;
    checks++;
    if (q_if.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_no_bypass got %b exp 0", q_if.deq_valid);
    end
    @(posedge clk); #1;
    q_if.enq_valid = 1'b0;
    q_if.enq_data  = '0;
    q_if.deq_ready = 1'b0;
    checks++;
    if (q_if.deq_valid !== 1'b1 || q_if.deq_data !== 4'h9) begin
      errors++;
      $display("FAIL empty_first got v=%b %h exp 1 9", q_if.deq_valid, q_if.deq_data);
    end
    @(negedge clk);
    q_if.deq_ready = 1'b1;
    @(posedge clk); #1;
    q_if.deq_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    enq(4'h5);
    exp_q = '{4'h5, 4'h6};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      q_if.enq_valid = 1'b1;
      q_if.enq_data  = (i == 0) ? 4'h6 : 4'h7;
      q_if.deq_ready = 1'b1;
      exp = exp_q.pop_front();
      checks++;
      if (q_if.deq_data !== exp) begin
        errors++;
        $display("FAIL b2b_head[%0d] got %h exp %h", i, q_if.deq_data, exp);
      end
      @(posedge clk); #1;
      checks++;
      if (q_if.count !== CW'(1)) begin
        errors++;
        $display("FAIL b2b_count[%0d] got %0d exp 1", i, q_if.count);
      end
    end
    q_if.enq_valid = 1'b0;
    q_if.enq_data  = '0;
    @(negedge clk);
    checks++;
    if (q_if.deq_data !== 4'h7) begin
      errors++;
      $display("FAIL b2b_last got %h exp 7", q_if.deq_data);
    end
    @(posedge clk); #1;
    q_if.deq_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    enq(4'h1); enq(4'h2); enq(4'h3);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (q_if.count !== '0 || q_if.empty !== 1'b1 || q_if.deq_data !== '0 || q_if.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got count=%0d empty=%b data=%h v=%b exp 0 1 0 0",
               q_if.count, q_if.empty, q_if.deq_data, q_if.deq_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_flush();
    enq(4'h1); enq(4'h2); enq(4'h3);
    @(negedge clk);
    q_if.flush     = 1'b1;
    q_if.enq_valid = 1'b1;
    q_if.enq_data  = 4'h7;
    q_if.deq_ready = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (q_if.count !== '0 || q_if.empty !== 1'b1 || q_if.deq_data !== '0) begin
      errors++;
      $display("FAIL flush got count=%0d empty=%b data=%h exp 0 1 0",
               q_if.count, q_if.empty, q_if.deq_data);
    end
    @(posedge clk); #1;
    checks++;
    if (q_if.deq_valid !== 1'b0 || q_if.count !== '0) begin
      errors++;
      $display("FAIL flush_hold got v=%b count=%0d exp 0 0", q_if.deq_valid, q_if.count);
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_stability();
    test_full();
    test_simultaneous();
    test_empty();
    test_back_to_back();
    test_mid_reset();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
